// File: rtl/score_glyph_loader.sv
`default_nettype none
// ============================================================================
// Module      : score_glyph_loader
// Description : Converts a binary score to 4 BCD digits (sequential
//               double-dabble), fetches their glyphs from font_rom and commits
//               them atomically with a leading-zero blank mask.
// Revision    : 1.0 - initial release
// ============================================================================
module score_glyph_loader (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        score_valid,
    output logic        score_ready,
    input  logic [13:0] score,
    output logic [3:0]  rom_addr,
    input  logic [31:0] rom_data,
    output logic [31:0] glyph3,
    output logic [31:0] glyph2,
    output logic [31:0] glyph1,
    output logic [31:0] glyph0,
    output logic [3:0]  blank_mask,
    output logic        glyphs_valid,
    output logic        update_done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_FETCH   = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    localparam logic [13:0] c_SCORE_MAX  = 14'd9999;
    localparam logic [3:0]  c_LAST_STEP  = 4'd13;
    localparam logic [3:0]  c_MASK_RESET = 4'b1110;

    state_t      r_state;
    state_t      w_state_next;
    logic [13:0] r_bin;
    logic [15:0] r_bcd;
    logic [3:0]  r_step;
    logic [1:0]  r_k;
    logic [31:0] r_shadow3;
    logic [31:0] r_shadow2;
    logic [31:0] r_shadow1;

    logic [13:0] w_sat;
    logic [15:0] w_adj;
    logic [29:0] w_shift;
    logic [3:0]  w_digit;
    logic [3:0]  w_mask;

    assign w_sat   = (score > c_SCORE_MAX) ? c_SCORE_MAX : score;
    assign w_shift = {w_adj, r_bin} << 1;
    // Digit (3-k): for a 2-bit k, 3-k equals ~k.
    assign w_digit = r_bcd[{~r_k, 2'b00} +: 4];

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        w_mask    = 4'b0000;
        w_mask[3] = (r_bcd[15:12] == 4'd0);
        w_mask[2] = w_mask[3] && (r_bcd[11:8] == 4'd0);
        w_mask[1] = w_mask[2] && (r_bcd[7:4] == 4'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        score_ready  = 1'b0;
        rom_addr     = 4'd0;
        case (r_state)
            S_IDLE: begin
                score_ready = 1'b1;
                if (score_valid) begin
                    w_state_next = S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (r_step == c_LAST_STEP) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                rom_addr = w_digit;
                if (r_k == 2'd3) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bin        <= '0;
            r_bcd        <= '0;
            r_step       <= '0;
            r_k          <= '0;
            r_shadow3    <= '0;
            r_shadow2    <= '0;
            r_shadow1    <= '0;
            glyph3       <= '0;
            glyph2       <= '0;
            glyph1       <= '0;
            glyph0       <= '0;
            blank_mask   <= c_MASK_RESET;
            glyphs_valid <= 1'b0;
            update_done  <= 1'b0;
        end else begin
            update_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (score_valid) begin
                        r_bin  <= w_sat;
                        r_bcd  <= '0;
                        r_step <= '0;
                        r_k    <= '0;
                    end
                end
                S_CONVERT: begin
                    r_bcd  <= w_shift[29:14];
                    r_bin  <= w_shift[13:0];
                    r_step <= r_step + 4'd1;
                end
                S_FETCH: begin
                    r_k <= r_k + 2'd1;
                    // rom_data now holds the glyph addressed in the previous cycle.
                    case (r_k)
                        2'd1:    r_shadow3 <= rom_data;
                        2'd2:    r_shadow2 <= rom_data;
                        2'd3:    r_shadow1 <= rom_data;
                        default: ;
                    endcase
                end
                S_DRAIN: begin
                    glyph3       <= r_shadow3;
                    glyph2       <= r_shadow2;
                    glyph1       <= r_shadow1;
                    glyph0       <= rom_data;
                    blank_mask   <= w_mask;
                    glyphs_valid <= 1'b1;
                    update_done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
